// File: rtl/fabric_pkg.sv
// Shared constants for the fabric memory ports.
package fabric_pkg;

  localparam int unsigned ERR_CODE_W = 8;

  localparam logic [ERR_CODE_W-1:0] ERR_NONE               = 8'h00;
  localparam logic [ERR_CODE_W-1:0] ERR_STORE_TAG_MISMATCH = 8'h01;
  localparam logic [ERR_CODE_W-1:0] ERR_STORE_SPURIOUS_ACK = 8'h02;

endpackage

// File: rtl/fabric_fifo.sv
// Synchronous FIFO with registered storage; the head is visible combinationally.
// The caller must never push when full without a simultaneous pop,
// and must never pop when empty.
module fabric_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

  // Next pointer and occupancy; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fabric_mem_store_port.sv
// Store port: pairs tagged address and data heads, issues single-beat
// writes, and returns one done token per acknowledged write.
module fabric_mem_store_port
  import fabric_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TAG_WIDTH       = 0,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_addr_valid,
  output logic                                     in_addr_ready,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0]          in_addr_data,
  input  logic                                     in_data_valid,
  output logic                                     in_data_ready,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0]          in_data_data,
  output logic                                     mem_wr_valid,
  input  logic                                     mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]                    mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                    mem_wr_data,
  input  logic                                     mem_wr_ack,
  output logic                                     out_done_valid,
  input  logic                                     out_done_ready,
  output logic [((TAG_WIDTH > 0) ? TAG_WIDTH : 1)-1:0] out_done_data,
  output logic                                     error_valid,
  output logic [ERR_CODE_W-1:0]                    error_code
);

  localparam int unsigned IN_W  = DATA_WIDTH + TAG_WIDTH;
  localparam int unsigned TW1   = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  // Reject illegal parameterisations at elaboration.
  if (DATA_WIDTH < 1) begin : g_chk_dw
    $fatal(1, "DATA_WIDTH must be >= 1");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > DATA_WIDTH) begin : g_chk_aw
    $fatal(1, "ADDR_WIDTH must be in 1..DATA_WIDTH");
  end
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_chk_qd
    $fatal(1, "QUEUE_DEPTH must be a power of two >= 2");
  end
  if (MAX_OUTSTANDING < 1 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_chk_mo
    $fatal(1, "MAX_OUTSTANDING must be a power of two >= 1");
  end

  logic [IN_W-1:0]  addr_head, data_head;
  logic             addr_empty, addr_full, data_empty, data_full;
  logic             pend_empty, pend_full;
  logic [TW1-1:0]   addr_tag, pend_tag_head;
  logic             tag_mismatch;
  logic             addr_push, data_push, issue, done_pop;
  logic             spurious_ack, ack_inc;

  logic [CNT_W-1:0] pending_cnt_q, pending_cnt_d;
  logic [CNT_W-1:0] acked_cnt_q, acked_cnt_d;
  logic             error_valid_q, error_valid_d;
  logic [ERR_CODE_W-1:0] error_code_q, error_code_d;

  // Input handshakes: readiness depends only on registered occupancy.
  assign in_addr_ready = !addr_full;
  assign in_data_ready = !data_full;
  assign addr_push     = in_addr_valid && in_addr_ready;
  assign data_push     = in_data_valid && in_data_ready;

  fabric_fifo #(.WIDTH(IN_W), .DEPTH(QUEUE_DEPTH)) u_addr_q (
    .clk(clk), .rst(rst),
    .push_i(addr_push), .wdata_i(in_addr_data),
    .pop_i(issue), .rdata_o(addr_head),
    .empty_o(addr_empty), .full_o(addr_full)
  );

  fabric_fifo #(.WIDTH(IN_W), .DEPTH(QUEUE_DEPTH)) u_data_q (
    .clk(clk), .rst(rst),
    .push_i(data_push), .wdata_i(in_data_data),
    .pop_i(issue), .rdata_o(data_head),
    .empty_o(data_empty), .full_o(data_full)
  );

  // Tags ride in the MSBs; untagged builds never mismatch and report tag 0.
  if (TAG_WIDTH > 0) begin : g_tagged
    assign addr_tag     = addr_head[IN_W-1:DATA_WIDTH];
    assign tag_mismatch = !addr_empty && !data_empty &&
                          (addr_head[IN_W-1:DATA_WIDTH] != data_head[IN_W-1:DATA_WIDTH]);
  end else begin : g_untagged
    assign addr_tag     = '0;
    assign tag_mismatch = 1'b0;
  end

  // Write issue from the paired heads, throttled by outstanding writes.
  assign mem_wr_valid = !addr_empty && !data_empty &&
                        (pending_cnt_q < CNT_W'(MAX_OUTSTANDING)) && !tag_mismatch;
  assign mem_wr_addr  = addr_head[ADDR_WIDTH-1:0];
  assign mem_wr_data  = data_head[DATA_WIDTH-1:0];
  assign issue        = mem_wr_valid && mem_wr_ready;

  // Pending-tag FIFO holds the tag of every issued write until its done pops.
  fabric_fifo #(.WIDTH(TW1), .DEPTH(MAX_OUTSTANDING)) u_pend_q (
    .clk(clk), .rst(rst),
    .push_i(issue), .wdata_i(addr_tag),
    .pop_i(done_pop), .rdata_o(pend_tag_head),
    .empty_o(pend_empty), .full_o(pend_full)
  );

  assign out_done_valid = (acked_cnt_q != '0);
  assign out_done_data  = pend_tag_head;
  assign done_pop       = out_done_valid && out_done_ready;

  // An ack with nothing outstanding is dropped and reported.
  assign spurious_ack = mem_wr_ack && (acked_cnt_q == pending_cnt_q);
  assign ack_inc      = mem_wr_ack && !spurious_ack;

  // Counter and sticky-error next state; the first error code wins.
  always_comb begin
    pending_cnt_d = pending_cnt_q + CNT_W'(issue) - CNT_W'(done_pop);
    acked_cnt_d   = acked_cnt_q + CNT_W'(ack_inc) - CNT_W'(done_pop);
    error_valid_d = error_valid_q;
    error_code_d  = error_code_q;
    if (!error_valid_q) begin
      if (tag_mismatch) begin
        error_valid_d = 1'b1;
        error_code_d  = ERR_STORE_TAG_MISMATCH;
      end else if (spurious_ack) begin
        error_valid_d = 1'b1;
        error_code_d  = ERR_STORE_SPURIOUS_ACK;
      end
    end
  end

  // Outstanding-write counters and error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_cnt_q <= '0;
      acked_cnt_q   <= '0;
      error_valid_q <= 1'b0;
      error_code_q  <= ERR_NONE;
    end else begin
      pending_cnt_q <= pending_cnt_d;
      acked_cnt_q   <= acked_cnt_d;
      error_valid_q <= error_valid_d;
      error_code_q  <= error_code_d;
    end
  end

  assign error_valid = error_valid_q;
  assign error_code  = error_code_q;

  // Address bits above ADDR_WIDTH and FIFO status flags not needed here.
  logic unused_bits;
  assign unused_bits = ^{addr_head, data_head, pend_empty, pend_full};

endmodule
